rat: RTL and testbench
======================

RAT -- requirements
Module: rat

Interface
REQ-001 Parameter ARCH_REGS, default 32, number of architectural registers (5-bit indices).
REQ-002 Parameter NUM_PHYS, default 64, number of physical registers; legal range 34..512.
REQ-003 Parameter TAG_W, default 9, physical tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 out_of_tags  out  1  free list cannot supply a full 2-wide bundle.
REQ-007 ren_valid  in  2  per-slot rename request; bit 0 is the older slot.
REQ-008 ren_src1 / ren_src2  in  10 each  per-slot source architectural registers, slot n at [5n+4:5n].
REQ-009 ren_has_target  in  2  per-slot destination present.
REQ-010 ren_dst  in  10  per-slot destination architectural register.
REQ-011 src1_tag / src2_tag  out  18 each  per-slot renamed source tags, slot n at [9n+8:9n].
REQ-012 dst_tag  out  18  per-slot newly allocated destination tag.
REQ-013 old_dst_tag  out  18  per-slot previous mapping of the destination, for later release.
REQ-014 free_valid  in  1  return one tag to the free list.
REQ-015 free_tag  in  9  tag being returned.
REQ-016 Port order is clk, reset, out_of_tags, then the remaining ports in the order listed; a 3-port positional hookup must elaborate.

Function
REQ-017 Map table: ARCH_REGS entries of TAG_W bits; free list: circular FIFO of NUM_PHYS-ARCH_REGS entries with head, tail and count.
REQ-018 Lookups (src/old_dst tags) are combinational from the current map table.
REQ-019 Slot allocates iff ren_valid=1, ren_has_target=1, ren_dst!=0, and the bundle is accepted.
REQ-020 Bundle accepted iff out_of_tags=0; otherwise no state change, and dst_tag outputs are 0.
REQ-021 out_of_tags=1 whenever free count < 2, combinationally from registered count.
REQ-022 Slot 0 takes the tag at head; slot 1 takes head+1 if slot 0 allocates, else head; head advances by the number allocated, modulo depth.
REQ-023 Bypass: a slot-1 source equal to an allocating slot-0 ren_dst returns slot 0's dst_tag.
REQ-024 Same ren_dst in both slots: slot 1's old_dst_tag = slot 0's new tag; the map ends with slot 1's tag.
REQ-025 Architectural r0 is never renamed: lookups of r0 return tag 0; dst r0 allocates nothing and returns dst_tag 0.
REQ-026 free_valid writes free_tag at tail; tail advances and count increments.
REQ-027 Free and allocate in the same cycle: count_next = count + free_valid - allocations; a tag freed this cycle is not allocatable until the next cycle.
REQ-028 free_valid when count equals depth is ignored.
REQ-029 Outputs for a slot with ren_valid=0 are don't-care, but driven (no X).

Reset
REQ-030 Asynchronous reset sets map entry i = i for every i.
REQ-031 Reset loads free list entries 0..depth-1 with tags ARCH_REGS..NUM_PHYS-1; head=0, tail=0, count=depth.
REQ-032 After reset, out_of_tags=0.
REQ-033 Reset asserted mid-bundle discards the bundle; no partial map update survives.

Configuration
REQ-034 Macro RAT_ASSERT_EN: when defined, simulation checks $error on: free while full; free_tag >= NUM_PHYS; free_tag < ARCH_REGS while free count was never drained; allocation while out_of_tags.
REQ-035 When RAT_ASSERT_EN is undefined, no checking code is compiled; functional behaviour is identical.

Verification
REQ-036 Reset, then slot0 src1=3, src2=5 -> src1_tag=3, src2_tag=5, out_of_tags=0.
REQ-037 Bundle slot0 dst=4, slot1 src1=4 dst=4 -> dst_tag0=32, dst_tag1=33, src1_tag1=32, old_dst_tag1=32; next cycle lookup r4 = 33.
REQ-038 Allocate 2 per cycle for 16 cycles -> out_of_tags=1 after the 16th; a 17th bundle is ignored and the map is unchanged.
REQ-039 From empty, free_valid with tag 7, then 9 -> out_of_tags=0 next cycle; next bundle dst tags are 7, 9.
REQ-040 dst=0 with has_target=1 -> dst_tag=0, head unchanged, r0 lookup still 0.
REQ-041 Simultaneous free of tag 40 and 2 allocations at count=2 -> count=1 and out_of_tags=1 next cycle; tag 40 is allocated on a later free refill.

Source files
------------

// File: rtl/rat.sv
// ---------------------------------------------------------------------------
// rat -- 2-wide register alias table with a circular free list.
//
// Renames up to two instructions per cycle. Source and previous-destination
// tags are looked up combinationally from the registered map table. Each slot
// that allocates takes the next tag from the free list. Tags come back to the
// free list one per cycle through free_valid/free_tag.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   out_of_tags    fewer than two free tags; the bundle is not accepted
//   ren_valid      [1:0] per-slot rename request, bit 0 is the older slot
//   ren_src1/2     [9:0] per-slot source arch regs, slot n at [5n+4:5n]
//   ren_has_target [1:0] per-slot destination present
//   ren_dst        [9:0] per-slot destination arch reg
//   src1_tag/2_tag [2*TAG_W-1:0] per-slot renamed sources, slot n at [TAG_W*n +: TAG_W]
//   dst_tag        [2*TAG_W-1:0] newly allocated tags (0 when nothing allocated)
//   old_dst_tag    [2*TAG_W-1:0] previous mapping of each destination
//   free_valid     return one tag this cycle
//   free_tag       [TAG_W-1:0] tag being returned
//
// Handshake: a bundle presented on ren_valid is consumed on the rising edge
// whenever out_of_tags is low in that cycle; when out_of_tags is high the
// bundle is dropped, with no state change, and the producer must present it
// again.
//
// Build option: define RAT_ASSERT_EN to compile simulation checks for illegal
// frees and for allocation while out_of_tags. They do not change behaviour.
// ---------------------------------------------------------------------------
module rat #(
    parameter int ARCH_REGS = 32,
    parameter int NUM_PHYS  = 64,
    parameter int TAG_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    output logic               out_of_tags,
    input  logic [1:0]         ren_valid,
    input  logic [9:0]         ren_src1,
    input  logic [9:0]         ren_src2,
    input  logic [1:0]         ren_has_target,
    input  logic [9:0]         ren_dst,
    output logic [2*TAG_W-1:0] src1_tag,
    output logic [2*TAG_W-1:0] src2_tag,
    output logic [2*TAG_W-1:0] dst_tag,
    output logic [2*TAG_W-1:0] old_dst_tag,
    input  logic               free_valid,
    input  logic [TAG_W-1:0]   free_tag
);

    localparam int DEPTH = NUM_PHYS - ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] map_q [ARCH_REGS];
    logic [TAG_W-1:0] fl_q  [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [4:0]       src1_0, src2_0, dst_0, src1_1, src2_1, dst_1;
    logic [1:0]       alloc;
    logic             free_ok;
    logic [PTR_W-1:0] head_1, head_next;
    logic [TAG_W-1:0] new_tag0, new_tag1;
    logic [CNT_W-1:0] count_next;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // r0 is hard-wired to tag 0 regardless of the table contents.
    function automatic logic [TAG_W-1:0] lookup(input logic [4:0] a);
        return (a == 5'd0) ? '0 : map_q[a];
    endfunction

    assign out_of_tags = (count_q < CNT_W'(2));

    always_comb begin
        src1_0 = ren_src1[4:0];
        src2_0 = ren_src2[4:0];
        dst_0  = ren_dst[4:0];
        src1_1 = ren_src1[9:5];
        src2_1 = ren_src2[9:5];
        dst_1  = ren_dst[9:5];

        alloc[0] = ren_valid[0] & ren_has_target[0] & (dst_0 != 5'd0) & ~out_of_tags;
        alloc[1] = ren_valid[1] & ren_has_target[1] & (dst_1 != 5'd0) & ~out_of_tags;

        // Slot 1 reads past slot 0's tag only when slot 0 actually took one.
        head_1    = alloc[0] ? ptr_inc(head_q) : head_q;
        head_next = alloc[1] ? ptr_inc(head_1) : head_1;
        new_tag0  = fl_q[head_q];
        new_tag1  = fl_q[head_1];

        src1_tag[TAG_W-1:0]    = lookup(src1_0);
        src2_tag[TAG_W-1:0]    = lookup(src2_0);
        old_dst_tag[TAG_W-1:0] = lookup(dst_0);

        // Intra-bundle bypass: slot 1 sees slot 0's new mapping. alloc[0]
        // already excludes dst r0, so r0 still reads as tag 0.
        src1_tag[2*TAG_W-1:TAG_W]    = (alloc[0] && src1_1 == dst_0) ? new_tag0 : lookup(src1_1);
        src2_tag[2*TAG_W-1:TAG_W]    = (alloc[0] && src2_1 == dst_0) ? new_tag0 : lookup(src2_1);
        old_dst_tag[2*TAG_W-1:TAG_W] = (alloc[0] && dst_1 == dst_0)  ? new_tag0 : lookup(dst_1);

        dst_tag[TAG_W-1:0]       = alloc[0] ? new_tag0 : '0;
        dst_tag[2*TAG_W-1:TAG_W] = alloc[1] ? new_tag1 : '0;

        // A return into a full list is dropped. The slot written at tail is
        // never one read at head this cycle, so a freed tag waits a cycle.
        free_ok    = free_valid & (count_q != CNT_W'(DEPTH));
        count_next = count_q + CNT_W'(free_ok) - CNT_W'(alloc[0]) - CNT_W'(alloc[1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= TAG_W'(i);
            for (int i = 0; i < DEPTH; i++)     fl_q[i]  <= TAG_W'(ARCH_REGS + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
        end else begin
            // Slot 1 is written last so it wins when both slots name the same reg.
            if (alloc[0]) map_q[dst_0] <= new_tag0;
            if (alloc[1]) map_q[dst_1] <= new_tag1;
            if (free_ok) begin
                fl_q[tail_q] <= free_tag;
                tail_q       <= ptr_inc(tail_q);
            end
            head_q  <= head_next;
            count_q <= count_next;
        end
    end

`ifdef RAT_ASSERT_EN
    // Set once the list has ever held fewer than DEPTH tags; before that, the
    // tags below ARCH_REGS are all still live in the map.
    logic drained_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          drained_q <= 1'b0;
        else if (count_q != CNT_W'(DEPTH)) drained_q <= 1'b1;
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (free_valid && count_q == CNT_W'(DEPTH))
                $error("rat: free_valid while free list is full");
            if (free_valid && int'(free_tag) >= NUM_PHYS)
                $error("rat: free_tag %0d out of range", free_tag);
            if (free_valid && int'(free_tag) < ARCH_REGS && !drained_q && count_q == CNT_W'(DEPTH))
                $error("rat: free_tag %0d is still an initial mapping", free_tag);
            if ((|alloc) && out_of_tags)
                $error("rat: allocation while out_of_tags");
        end
    end
`else
    // No checking logic in the default build.
`endif

endmodule

// File: tb/tb_rat.sv
module tb_rat;

  localparam int TAG_W = 9;

  localparam logic [3:0] OOT  = 4'd0;
  localparam logic [3:0] S1_0 = 4'd1;
  localparam logic [3:0] S2_0 = 4'd2;
  localparam logic [3:0] DST0 = 4'd3;
  localparam logic [3:0] OLD0 = 4'd4;
  localparam logic [3:0] S1_1 = 4'd5;
  localparam logic [3:0] S2_1 = 4'd6;
  localparam logic [3:0] DST1 = 4'd7;
  localparam logic [3:0] OLD1 = 4'd8;

  logic               clk;
  logic               reset;
  logic               out_of_tags;
  logic [1:0]         ren_valid;
  logic [9:0]         ren_src1;
  logic [9:0]         ren_src2;
  logic [1:0]         ren_has_target;
  logic [9:0]         ren_dst;
  logic [2*TAG_W-1:0] src1_tag;
  logic [2*TAG_W-1:0] src2_tag;
  logic [2*TAG_W-1:0] dst_tag;
  logic [2*TAG_W-1:0] old_dst_tag;
  logic               free_valid;
  logic [TAG_W-1:0]   free_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TAG_W-1:0] exp_q[$];
  logic [3:0]       sel_q[$];

  rat #(.ARCH_REGS(32), .NUM_PHYS(64), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .out_of_tags    (out_of_tags),
    .ren_valid      (ren_valid),
    .ren_src1       (ren_src1),
    .ren_src2       (ren_src2),
    .ren_has_target (ren_has_target),
    .ren_dst        (ren_dst),
    .src1_tag       (src1_tag),
    .src2_tag       (src2_tag),
    .dst_tag        (dst_tag),
    .old_dst_tag    (old_dst_tag),
    .free_valid     (free_valid),
    .free_tag       (free_tag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic string sel_name(input logic [3:0] sel);
    case (sel)
      OOT:     return "out_of_tags";
      S1_0:    return "src1_tag0";
      S2_0:    return "src2_tag0";
      DST0:    return "dst_tag0";
      OLD0:    return "old_dst_tag0";
      S1_1:    return "src1_tag1";
      S2_1:    return "src2_tag1";
      DST1:    return "dst_tag1";
      default: return "old_dst_tag1";
    endcase
  endfunction

  function automatic logic [TAG_W-1:0] observe(input logic [3:0] sel);
    case (sel)
      OOT:     return TAG_W'(out_of_tags);
      S1_0:    return src1_tag[TAG_W-1:0];
      S2_0:    return src2_tag[TAG_W-1:0];
      DST0:    return dst_tag[TAG_W-1:0];
      OLD0:    return old_dst_tag[TAG_W-1:0];
      S1_1:    return src1_tag[2*TAG_W-1:TAG_W];
      S2_1:    return src2_tag[2*TAG_W-1:TAG_W];
      DST1:    return dst_tag[2*TAG_W-1:TAG_W];
      default: return old_dst_tag[2*TAG_W-1:TAG_W];
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [1:0] v, input logic [1:0] ht,
                       input int s1_0, input int s2_0, input int d0,
                       input int s1_1, input int s2_1, input int d1,
                       input logic fv, input int ft);
    ren_valid      = v;
    ren_has_target = ht;
    ren_src1       = {5'(s1_1), 5'(s1_0)};
    ren_src2       = {5'(s2_1), 5'(s2_0)};
    ren_dst        = {5'(d1), 5'(d0)};
    free_valid     = fv;
    free_tag       = TAG_W'(ft);
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic free_one(input int t);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1'b1, t);
  endtask

  task automatic expect_val(input logic [3:0] sel, input int val);
    sel_q.push_back(sel);
    exp_q.push_back(TAG_W'(val));
  endtask

  // scoreboard: drain every expectation at the falling edge, then let the
  // rising edge commit the step and return just after it
  task automatic check_step();
    logic [3:0]       sel;
    logic [TAG_W-1:0] exp_v;
    logic [TAG_W-1:0] obs;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      sel   = sel_q.pop_front();
      exp_v = exp_q.pop_front();
      obs   = observe(sel);
      n_checks++;
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", sel_name(sel), obs, exp_v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // identity map after reset
    drive(2'b11, 2'b00, 3, 5, 0, 0, 31, 0, 1'b0, 0);
    expect_val(OOT, 0); expect_val(S1_0, 3); expect_val(S2_0, 5);
    expect_val(S1_1, 0); expect_val(S2_1, 31);
    check_step();

    // same destination in both slots, slot 1 reads it
    drive(2'b11, 2'b11, 1, 2, 4, 4, 4, 4, 1'b0, 0);
    expect_val(DST0, 32); expect_val(DST1, 33); expect_val(OLD0, 4);
    expect_val(S1_1, 32); expect_val(S2_1, 32); expect_val(OLD1, 32);
    expect_val(S1_0, 1);  expect_val(S2_0, 2);
    check_step();

    // r4 now maps to slot 1's tag; dst r0 allocates nothing
    drive(2'b01, 2'b01, 4, 0, 0, 0, 0, 0, 1'b0, 0);
    expect_val(S1_0, 33); expect_val(S2_0, 0); expect_val(DST0, 0);
    expect_val(OLD0, 0);  expect_val(OOT, 0);
    check_step();

    // head did not move for the r0 destination
    drive(2'b01, 2'b01, 5, 0, 5, 0, 0, 0, 1'b0, 0);
    expect_val(DST0, 34); expect_val(OLD0, 5); expect_val(S1_0, 5);
    check_step();

    // slot 1 alone allocates from head; no bypass without slot 0 target
    drive(2'b11, 2'b10, 5, 0, 6, 5, 0, 7, 1'b0, 0);
    expect_val(DST0, 0); expect_val(DST1, 35); expect_val(OLD1, 7); expect_val(S1_1, 34);
    check_step();

    // reset arrives while a bundle is driven: the bundle must not survive
    drive(2'b01, 2'b01, 0, 0, 6, 0, 0, 0, 1'b0, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b11, 2'b00, 6, 4, 0, 7, 5, 0, 1'b0, 0);
    expect_val(OOT, 0); expect_val(S1_0, 6); expect_val(S2_0, 4);
    expect_val(S1_1, 7); expect_val(S2_1, 5);
    check_step();

    // return into a full list is ignored
    free_one(50);
    expect_val(OOT, 0);
    check_step();

    // drain the list two tags per cycle
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, 2'b11, 3, 0, 8, 8, 0, 9, 1'b0, 0);
      expect_val(OOT, 0);
      expect_val(DST0, 32 + 2 * i);
      expect_val(DST1, 33 + 2 * i);
      expect_val(S1_1, 32 + 2 * i);
      expect_val(OLD0, (i == 0) ? 8 : 30 + 2 * i);
      expect_val(OLD1, (i == 0) ? 9 : 31 + 2 * i);
      expect_val(S1_0, 3);
      check_step();
    end

    // 17th bundle is refused
    drive(2'b11, 2'b11, 3, 0, 8, 8, 0, 9, 1'b0, 0);
    expect_val(OOT, 1); expect_val(DST0, 0); expect_val(DST1, 0);
    expect_val(OLD0, 62); expect_val(OLD1, 63);
    check_step();

    drive(2'b11, 2'b00, 8, 9, 0, 9, 8, 0, 1'b0, 0);
    expect_val(OOT, 1); expect_val(S1_0, 62); expect_val(S2_0, 63);
    expect_val(S1_1, 63); expect_val(S2_1, 62);
    check_step();

    // refill from empty with 7 then 9
    free_one(7);
    expect_val(OOT, 1);
    check_step();
    free_one(9);
    expect_val(OOT, 1);
    check_step();
    drive(2'b11, 2'b11, 8, 9, 10, 10, 0, 11, 1'b0, 0);
    expect_val(OOT, 0); expect_val(DST0, 7); expect_val(DST1, 9);
    expect_val(S1_1, 7); expect_val(OLD0, 10);
    expect_val(S1_0, 62); expect_val(S2_0, 63);
    check_step();

    // bring count to 2, then free 40 while allocating two
    free_one(20);
    expect_val(OOT, 1);
    check_step();
    free_one(21);
    expect_val(OOT, 1);
    check_step();
    drive(2'b11, 2'b11, 0, 0, 12, 0, 0, 13, 1'b1, 40);
    expect_val(OOT, 0); expect_val(DST0, 20); expect_val(DST1, 21);
    check_step();

    // only one tag (40) left: refused
    drive(2'b11, 2'b11, 0, 0, 12, 0, 0, 13, 1'b0, 0);
    expect_val(OOT, 1); expect_val(DST0, 0); expect_val(DST1, 0); expect_val(OLD0, 20);
    check_step();

    free_one(22);
    expect_val(OOT, 1);
    check_step();
    drive(2'b11, 2'b11, 0, 0, 14, 0, 0, 15, 1'b0, 0);
    expect_val(OOT, 0); expect_val(DST0, 40); expect_val(DST1, 22); expect_val(OLD1, 15);
    check_step();

    // final map contents
    drive(2'b11, 2'b00, 12, 13, 0, 14, 15, 0, 1'b0, 0);
    expect_val(S1_0, 20); expect_val(S2_0, 21); expect_val(S1_1, 40); expect_val(S2_1, 22);
    expect_val(OOT, 1);
    check_step();

    idle();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
